// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiter and future schedulers.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;

  localparam int unsigned COUNT_WIDTH = 16;
  localparam int unsigned RR_MAX      = 64;
  localparam int unsigned RR_IDX_W    = 6;

  // First set request strictly after 'last', wrapping modulo n (n <= RR_MAX).
  function automatic logic rr_search(input  logic [RR_MAX-1:0] req,
                                     input  int unsigned       last,
                                     input  int unsigned       n,
                                     output int unsigned       idx);
    logic        found;
    int unsigned cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        cand = last + k;
        if (cand >= n) cand = cand - n;
        if (!found && req[cand[RR_IDX_W-1:0]]) begin
          found = 1'b1;
          idx   = cand;
        end
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module round_robin_select
  import axis_arb_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned SEL_BITS = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [SEL_BITS-1:0] last_grant,
  output logic                found,
  output logic [SEL_BITS-1:0] idx
);

  logic [RR_MAX-1:0] req_ext;
  int unsigned       idx_int;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    idx_int        = '0;
    found          = rr_search(req_ext, 32'(last_grant), N, idx_int);
    idx            = SEL_BITS'(idx_int);
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin whole-packet arbiter sharing one AXI stream among NUM_INPUTS sources.
// Optional per-input packet counters: define AXIS_PACKET_ARBITER_COUNT_EN.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS     = 2,
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter int unsigned SEL_BITS       = $clog2(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 sresetn,
  output logic [NUM_INPUTS-1:0]                axis_i_tready,
  input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES-1:0]     axis_i_tkeep,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                                 axis_o_tready,
  output logic                                 axis_o_tvalid,
  output logic                                 axis_o_tlast,
  output logic [AXIS_BYTES-1:0]                axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0]              axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
`ifdef AXIS_PACKET_ARBITER_COUNT_EN
  output logic [NUM_INPUTS*COUNT_WIDTH-1:0]    pkt_count,
`endif
  output logic [SEL_BITS-1:0]                  axis_o_src
);

  arb_state_t           state_q, state_d;
  logic [SEL_BITS-1:0]  grant_q, grant_d;
  logic [SEL_BITS-1:0]  last_grant_q, last_grant_d;
  logic                 rr_found;
  logic [SEL_BITS-1:0]  rr_idx;

  logic                      sel_valid, sel_last;
  logic [AXIS_BYTES-1:0]     sel_keep;
  logic [AXIS_BYTES*8-1:0]   sel_data;
  logic [AXIS_USER_BITS-1:0] sel_user;

  round_robin_select #(
    .N        (NUM_INPUTS),
    .SEL_BITS (SEL_BITS)
  ) u_rr (
    .req        (axis_i_tvalid),
    .last_grant (last_grant_q),
    .found      (rr_found),
    .idx        (rr_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_keep  = '0;
    sel_data  = '0;
    sel_user  = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (SEL_BITS'(i) == grant_q) begin
        sel_valid = axis_i_tvalid[i];
        sel_last  = axis_i_tlast[i];
        sel_keep  = axis_i_tkeep[i*AXIS_BYTES +: AXIS_BYTES];
        sel_data  = axis_i_tdata[i*AXIS_BYTES*8 +: AXIS_BYTES*8];
        sel_user  = axis_i_tuser[i*AXIS_USER_BITS +: AXIS_USER_BITS];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = sel_last;
    axis_o_tkeep  = sel_keep;
    axis_o_tdata  = sel_data;
    axis_o_tuser  = sel_user;
    axis_i_tready = '0;
    axis_o_src    = grant_q;
    if (state_q == ARB_IDLE) begin
      if (rr_found) begin
        grant_d = rr_idx;
        state_d = ARB_PASS;
      end
    end else begin
      axis_o_tvalid = sel_valid;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (SEL_BITS'(i) == grant_q) axis_i_tready[i] = axis_o_tready;
      end
      if (sel_valid && axis_o_tready && sel_last) begin
        last_grant_d = grant_q;
        state_d      = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_BITS'(NUM_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef AXIS_PACKET_ARBITER_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_INPUTS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_INPUTS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (axis_o_tvalid && axis_o_tready && axis_o_tlast && SEL_BITS'(i) == grant_q)
        cnt_d[i] = cnt_q[i] + 1'b1;
      pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter with four inputs, one byte per beat.
module tb_axis_packet_arbiter;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic [3:0]  i_tready, i_valid, i_last, i_keep, i_user;
  logic [31:0] i_data;
  logic        o_tready, o_tvalid, o_tlast;
  logic [0:0]  o_tkeep, o_tuser;
  logic [7:0]  o_tdata;
  logic [1:0]  o_src;
`ifdef AXIS_PACKET_ARBITER_COUNT_EN
  logic [63:0] pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  axis_packet_arbiter #(
    .NUM_INPUTS     (N),
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (1)
  ) dut (
    .clk           (clk),
    .sresetn       (sresetn),
    .axis_i_tready (i_tready),
    .axis_i_tvalid (i_valid),
    .axis_i_tlast  (i_last),
    .axis_i_tkeep  (i_keep),
    .axis_i_tdata  (i_data),
    .axis_i_tuser  (i_user),
    .axis_o_tready (o_tready),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tlast  (o_tlast),
    .axis_o_tkeep  (o_tkeep),
    .axis_o_tdata  (o_tdata),
    .axis_o_tuser  (o_tuser),
`ifdef AXIS_PACKET_ARBITER_COUNT_EN
    .pkt_count     (pkt_count),
`endif
    .axis_o_src    (o_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sresetn = 1'b0;
    i_valid = '0; i_last = '0; i_keep = '1; i_user = '0; i_data = '0;
    o_tready = 1'b1;
    cyc(); cyc();
    sresetn = 1'b1;
  endtask

  int   beat [4];
  int   order [$];
  int   xfers, nhs, b;
  logic hs, src_hs, done;
  logic [1:0] hs_src;

  task automatic drive_all();
    for (int k = 0; k < 4; k++) begin
      i_data[8*k +: 8] = 8'(k*16 + beat[k]);
      i_last[k]        = (beat[k] == 1);
    end
  endtask

  initial begin
    // Reset state
    sresetn = 1'b0;
    i_valid = '0; i_last = '0; i_keep = '1; i_user = '0; i_data = '0; o_tready = 1'b1;
    #3;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tready", 64'(i_tready), 64'd0);
    check("rst_src",    64'(o_src),    64'd0);
    do_reset();

    // 3-beat packet on input 1
    i_valid = 4'b0010; i_data[15:8] = 8'h11; i_last = '0;
    #1;
    check("t1_idle_tvalid", 64'(o_tvalid), 64'd0);
    check("t1_idle_tready", 64'(i_tready), 64'd0);
    cyc(); #1;
    check("t1_b0_tvalid", 64'(o_tvalid), 64'd1);
    check("t1_b0_src",    64'(o_src),    64'd1);
    check("t1_b0_data",   64'(o_tdata),  64'h11);
    check("t1_b0_tready", 64'(i_tready), 64'b0010);
    cyc(); i_data[15:8] = 8'h12; #1;
    check("t1_b1_data",   64'(o_tdata),  64'h12);
    check("t1_b1_tready", 64'(i_tready), 64'b0010);
    cyc(); i_data[15:8] = 8'h13; i_last[1] = 1'b1; #1;
    check("t1_b2_data",   64'(o_tdata),  64'h13);
    check("t1_b2_tlast",  64'(o_tlast),  64'd1);
    cyc(); i_valid = '0; i_last = '0; #1;
    check("t1_end_tvalid", 64'(o_tvalid), 64'd0);

    // Fairness: all four inputs stream 2-beat packets
    do_reset();
    for (int k = 0; k < 4; k++) beat[k] = 0;
    drive_all();
    i_valid = 4'hF;
    xfers = 0;
    order.delete();
    for (int c = 0; c < 15; c++) begin
      #1;
      hs = o_tvalid && o_tready;
      hs_src = o_src;
      if (hs) begin
        check("t2_data", 64'(o_tdata), 64'(hs_src*16 + beat[hs_src]));
        if (beat[hs_src] == 0) order.push_back(int'(hs_src));
        if (c < 12) xfers++;
      end
      cyc();
      if (hs) begin
        beat[hs_src] = beat[hs_src] ^ 1;
        drive_all();
      end
    end
    check("t2_xfers_12cyc", 64'(xfers), 64'd8);
    check("t2_npkts", 64'(order.size()), 64'd5);
    if (order.size() == 5) begin
      check("t2_order0", 64'(order[0]), 64'd0);
      check("t2_order1", 64'(order[1]), 64'd1);
      check("t2_order2", 64'(order[2]), 64'd2);
      check("t2_order3", 64'(order[3]), 64'd3);
      check("t2_order4", 64'(order[4]), 64'd0);
    end

    // Stall on granted input 0 while input 2 waits with a single-beat packet
    do_reset();
    i_valid = 4'b0001; i_data = 32'h0000_0001; i_last = '0;
    #1;
    check("t3_idle", 64'(o_tvalid), 64'd0);
    cyc(); #1;
    check("t3_b0_src",  64'(o_src),   64'd0);
    check("t3_b0_data", 64'(o_tdata), 64'h01);
    cyc();
    i_valid = 4'b0100; i_data = 32'h0021_0002; i_last = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_stall_tvalid", 64'(o_tvalid), 64'd0);
      check("t3_stall_src",    64'(o_src),    64'd0);
      check("t3_stall_tready", 64'(i_tready), 64'b0001);
      cyc();
    end
    i_valid = 4'b0101; #1;
    check("t3_b1_tvalid", 64'(o_tvalid), 64'd1);
    check("t3_b1_data",   64'(o_tdata),  64'h02);
    cyc(); i_data[7:0] = 8'h03; i_last[0] = 1'b1; #1;
    check("t3_b2_tlast",  64'(o_tlast),  64'd1);
    check("t3_b2_src",    64'(o_src),    64'd0);
    cyc(); i_valid[0] = 1'b0; i_last[0] = 1'b0; #1;
    check("t3_gap_tvalid", 64'(o_tvalid), 64'd0);
    check("t3_gap_tready", 64'(i_tready), 64'd0);
    cyc(); #1;
    check("t3_p2_src",    64'(o_src),    64'd2);
    check("t3_p2_data",   64'(o_tdata),  64'h21);
    check("t3_p2_tlast",  64'(o_tlast),  64'd1);
    check("t3_p2_tready", 64'(i_tready), 64'b0100);
    cyc(); i_valid = '0; i_last = '0; #1;
    check("t3_end", 64'(o_tvalid), 64'd0);

    // 10-beat packet on input 1 with random downstream backpressure
    b = 0; nhs = 0; done = 1'b0;
    i_valid = 4'b0010; i_data[15:8] = 8'h40; i_last = '0;
    for (int c = 0; c < 80 && !done; c++) begin
      o_tready = 1'($urandom_range(0, 1));
      #1;
      check("t4_mirror", 64'(i_tready), o_tvalid ? 64'({2'b00, o_tready, 1'b0}) : 64'd0);
      src_hs = i_tready[1] && i_valid[1];
      if (o_tvalid && o_tready) begin
        check("t4_data", 64'(o_tdata), 64'(8'h40 + nhs));
        nhs++;
      end
      cyc();
      if (src_hs) begin
        if (b == 9) begin
          done = 1'b1;
          i_valid = '0; i_last = '0;
        end else begin
          b++;
          i_data[15:8] = 8'(8'h40 + b);
          i_last[1]    = (b == 9);
        end
      end
    end
    check("t4_done", 64'(done), 64'd1);
    check("t4_beats", 64'(nhs), 64'd10);
    o_tready = 1'b1;

    // Asynchronous reset during beat 2 of a packet from input 3
    i_valid = 4'b1000; i_data = 32'h3100_0000; i_last = '0;
    cyc(); #1;
    check("t5_b0_src", 64'(o_src), 64'd3);
    cyc(); i_data[31:24] = 8'h32; #1;
    check("t5_b1_tvalid", 64'(o_tvalid), 64'd1);
    #2 sresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", 64'(o_tvalid), 64'd0);
    check("t5_rst_tready", 64'(i_tready), 64'd0);
    check("t5_rst_src",    64'(o_src),    64'd0);
    cyc();
    sresetn = 1'b1;
    i_valid = 4'b1001; i_data = 32'h3100_0005; i_last = '0;
    #1;
    check("t5_idle", 64'(o_tvalid), 64'd0);
    cyc(); #1;
    check("t5_regrant_src",  64'(o_src),   64'd0);
    check("t5_regrant_data", 64'(o_tdata), 64'h05);

`ifdef AXIS_PACKET_ARBITER_COUNT_EN
    // Three single-beat packets on input 1
    do_reset();
    i_valid = 4'b0010; i_last = 4'b0010; i_data = 32'h0000_7700;
    repeat (6) cyc();
    i_valid = '0; i_last = '0;
    #1;
    check("t6_pkt_count", pkt_count, 64'h0000_0000_0003_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
